regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Sequencing and arbitration controller for the dual-read, single-write 32-entry register file. It keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards. It drives the register file read addresses at issue, presents operands one cycle later with x0 zeroing and same-cycle write forwarding, and shares the single write port between the ALU and LSU writeback sources. It sits between decode/issue and the register file.

## Interface

No parameters; XLEN = 32 and 32 architectural registers are fixed.

- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- iss_valid  in  1  decoded instruction presented
- iss_ready  out  1  no hazard; instruction accepted when iss_valid & iss_ready (fire)
- iss_rs1, iss_rs2  in  5 each  source register indices
- iss_rs1_en, iss_rs2_en  in  1 each  source actually used
- iss_rd  in  5  destination index
- iss_rd_we  in  1  instruction writes rd
- op_valid  out  1  operands valid (one cycle after fire)
- op_a, op_b  out  32 each  operand values, 0 when op_valid = 0
- alu_wb_valid, alu_wb_ready  in/out  1 each  ALU writeback handshake
- alu_wb_rd, alu_wb_data  in  5/32  ALU writeback target and value
- lsu_wb_valid, lsu_wb_ready  in/out  1 each  LSU writeback handshake
- lsu_wb_rd, lsu_wb_data  in  5/32  LSU writeback target and value
- rf_r0addr, rf_r1addr  out  5 each  to register file read ports
- rf_r0data, rf_r1data  in  32 each  from register file (registered, 1-cycle latency)
- rf_waddr, rf_wdata, rf_wren  out  5/32/1  to register file write port
- busy_vec  out  32  scoreboard, bit 0 always 0
- wb_err  out  1  one-cycle pulse: writeback accepted to a non-busy register (rd ≠ 0)

## Operation

- Scoreboard: busy[31:1]. set = fire & iss_rd_we & iss_rd ≠ 0, applied to busy[iss_rd]. clr = write-port fire with rd ≠ 0, applied to busy[rd]. busy_next = (busy & ~clr) | set; set wins when both target the same register.
- Hazard: a source or destination register counts as busy if busy[r] = 1 and it is not cleared this cycle. Register index 0 is never busy.
- iss_ready = !(rs1_en & busy'(rs1) | rs2_en & busy'(rs2) | rd_we & busy'(rd)). iss_ready does not depend on iss_valid.
- Read addressing: rf_r0addr = iss_rs1 and rf_r1addr = iss_rs2, combinationally, every cycle.
- Operand stage: on fire, register rs1/rs2, their enables, forward flags (fwd_a = write-port fire & rd ≠ 0 & rd = rs1; same for fwd_b), and rf_wdata.
- In the next cycle, op_a = 0 if rs1 = 0 or !rs1_en; the registered wdata if fwd_a; otherwise rf_r0data. op_b is selected the same way.
- Writeback arbiter:
  - One valid source is granted the same cycle.
  - If both are valid, the source given by pointer prio is granted; prio toggles to the other source only after a conflicted grant.
  - ready = grant. rf_waddr/rf_wdata come from the granted source.
  - rf_wren = grant & rd ≠ 0. An rd = 0 writeback consumes the port cycle with no write.
- wb_err: pulses in the cycle of a granted writeback with rd ≠ 0 and busy[rd] = 0. The write is still performed.

## Timing

- Reset (async): busy = 0, op_valid = 0, op_a = op_b = 0, prio = LSU, operand registers = 0, wb_err = 0. rf_wren = 0 while nrst = 0.
- Issue-to-operand latency: exactly 1 cycle. op_valid is high for one cycle per fire. There is no backpressure on operands.
- Issue fire is possible every cycle. Back-to-back dependent instructions stall until the producing writeback's grant cycle; issue can fire in that same cycle via forwarding.
- Writeback fire to the register file write: same cycle (rf_wren combinational). The new value is readable from rf_r*data by an issue fired in the next cycle.
- A valid writeback source holds rd/data until ready.
- nrst asserted mid-operation discards the scoreboard and the operand stage immediately; in-flight writebacks are dropped.

## Test plan

- Reset then idle: busy_vec = 0, op_valid = 0, op_a = op_b = 0, rf_wren = 0, alu/lsu ready follow valid.
- Issue rd = x5 (rd_we), then issue rs1 = x5 -> busy_vec[5] = 1 and second iss_ready = 0. When ALU writes x5 = 0xDEADBEEF, the same-cycle issue fires and the next cycle op_a = 0xDEADBEEF (forwarded).
- Issue rs1 = x0, rs2 = x3 (x3 holds 0x1234) -> next cycle op_a = 0, op_b = 0x1234, op_valid = 1 for one cycle.
- ALU and LSU both valid for 4 cycles with distinct rds -> grants LSU, ALU, LSU, ALU; rf_wren each cycle.
- Issue rd = x7 in the same cycle LSU writes x7 (busy) -> issue fires and busy_vec[7] stays 1 (set wins). Then a writeback to x0 -> rf_wren = 0 and no wb_err.
- ALU writeback to x9 with busy[9] = 0 -> wb_err pulse and x9 is written. Assert nrst during a pending stall -> busy_vec = 0 and iss_ready = 1 after release.

Source files
------------

// File: rtl/regfile_ctrl_if.sv
// rtl/regfile_ctrl_if.sv - issue, operand, writeback and register-file port bundle for regfile_ctrl
interface regfile_ctrl_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_rs1_en;
  logic        iss_rs2_en;
  logic [4:0]  iss_rd;
  logic        iss_rd_we;
  logic        op_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        alu_wb_valid;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid;
  logic        lsu_wb_ready;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic [4:0]  rf_r0addr;
  logic [4:0]  rf_r1addr;
  logic [31:0] rf_r0data;
  logic [31:0] rf_r1data;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wren;
  logic [31:0] busy_vec;
  logic        wb_err;

  // controller side
  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_rd_we,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    input  rf_r0data, rf_r1data,
    output iss_ready, op_valid, op_a, op_b, alu_wb_ready, lsu_wb_ready,
    output rf_r0addr, rf_r1addr, rf_waddr, rf_wdata, rf_wren, busy_vec, wb_err
  );

  // issue/writeback/register-file side
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rs1_en, iss_rs2_en, iss_rd, iss_rd_we,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
    output rf_r0data, rf_r1data,
    input  iss_ready, op_valid, op_a, op_b, alu_wb_ready, lsu_wb_ready,
    input  rf_r0addr, rf_r1addr, rf_waddr, rf_wdata, rf_wren, busy_vec, wb_err
  );
endinterface

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - register file scoreboard, issue hazard stall, operand forwarding and writeback arbiter
module regfile_ctrl (
  input logic          clk,
  input logic          nrst,
  regfile_ctrl_if.slave bus
);
  localparam logic PRIO_ALU = 1'b0;
  localparam logic PRIO_LSU = 1'b1;

  logic [31:0] busy;
  logic        prio;
  logic        gnt_alu;
  logic        gnt_lsu;
  logic        wb_fire;
  logic        wr_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic [31:0] busy_eff;
  logic        fire;

  logic        opv_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic        en1_q;
  logic        en2_q;
  logic        fwd_a_q;
  logic        fwd_b_q;
  logic [31:0] wdata_q;

  // writeback arbitration: a lone requester wins, a conflict goes to prio
  always_comb begin
    gnt_alu = bus.alu_wb_valid & (~bus.lsu_wb_valid | (prio == PRIO_ALU));
    gnt_lsu = bus.lsu_wb_valid & (~bus.alu_wb_valid | (prio == PRIO_LSU));
    wb_fire = gnt_alu | gnt_lsu;
    wb_rd   = gnt_lsu ? bus.lsu_wb_rd : bus.alu_wb_rd;
    wb_data = gnt_lsu ? bus.lsu_wb_data : bus.alu_wb_data;
    // an rd = 0 writeback uses the port cycle without writing; nothing writes in reset
    wr_en   = wb_fire & (wb_rd != 5'd0) & nrst;
  end

  assign bus.alu_wb_ready = gnt_alu;
  assign bus.lsu_wb_ready = gnt_lsu;
  assign bus.rf_waddr     = wb_rd;
  assign bus.rf_wdata     = wb_data;
  assign bus.rf_wren      = wr_en;
  assign bus.wb_err       = wr_en & ~busy[wb_rd];

  // hazard check against the scoreboard as it looks after this cycle's clear
  always_comb begin
    clr_vec  = wr_en ? (32'd1 << wb_rd) : 32'd0;
    busy_eff = busy & ~clr_vec;
    fire     = bus.iss_valid & bus.iss_ready;
    set_vec  = (fire & bus.iss_rd_we & (bus.iss_rd != 5'd0)) ? (32'd1 << bus.iss_rd) : 32'd0;
  end

  assign bus.iss_ready = ~((bus.iss_rs1_en & busy_eff[bus.iss_rs1]) |
                           (bus.iss_rs2_en & busy_eff[bus.iss_rs2]) |
                           (bus.iss_rd_we  & busy_eff[bus.iss_rd]));
  assign bus.rf_r0addr = bus.iss_rs1;
  assign bus.rf_r1addr = bus.iss_rs2;
  assign bus.busy_vec  = busy;

  // scoreboard update; a new set beats a same-cycle clear, x0 never busy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) busy <= 32'd0;
    else       busy <= ((busy & ~clr_vec) | set_vec) & ~32'd1;
  end

  // priority pointer moves to the loser only after a conflicted grant
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prio <= PRIO_LSU;
    end else if (bus.alu_wb_valid & bus.lsu_wb_valid) begin
      prio <= gnt_lsu ? PRIO_ALU : PRIO_LSU;
    end
  end

  // operand stage: capture sources and forward flags at issue fire
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      opv_q   <= 1'b0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      fwd_a_q <= 1'b0;
      fwd_b_q <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      opv_q <= fire;
      if (fire) begin
        rs1_q   <= bus.iss_rs1;
        rs2_q   <= bus.iss_rs2;
        en1_q   <= bus.iss_rs1_en;
        en2_q   <= bus.iss_rs2_en;
        fwd_a_q <= wr_en & (wb_rd == bus.iss_rs1);
        fwd_b_q <= wr_en & (wb_rd == bus.iss_rs2);
        wdata_q <= wb_data;
      end
    end
  end

  // operand select: x0/unused -> 0, then forwarded write, then register file data
  always_comb begin
    bus.op_valid = opv_q;
    bus.op_a     = 32'd0;
    bus.op_b     = 32'd0;
    if (opv_q) begin
      if (en1_q && rs1_q != 5'd0) bus.op_a = fwd_a_q ? wdata_q : bus.rf_r0data;
      if (en2_q && rs2_q != 5'd0) bus.op_b = fwd_b_q ? wdata_q : bus.rf_r1data;
    end
  end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - directed self-checking bench for regfile_ctrl
module tb_regfile_ctrl;
  logic clk = 1'b0;
  logic nrst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] rf_mem [32];

  regfile_ctrl_if bus ();

  regfile_ctrl dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // register file model: registered reads return the pre-write value
  always @(posedge clk) begin
    bus.rf_r0data <= rf_mem[bus.rf_r0addr];
    bus.rf_r1data <= rf_mem[bus.rf_r1addr];
    if (bus.rf_wren) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iss_valid    = 1'b0;
    bus.iss_rs1      = 5'd0;
    bus.iss_rs2      = 5'd0;
    bus.iss_rs1_en   = 1'b0;
    bus.iss_rs2_en   = 1'b0;
    bus.iss_rd       = 5'd0;
    bus.iss_rd_we    = 1'b0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = 5'd0;
    bus.alu_wb_data  = 32'd0;
    bus.lsu_wb_valid = 1'b0;
    bus.lsu_wb_rd    = 5'd0;
    bus.lsu_wb_data  = 32'd0;
  endtask

  logic [4:0] arb_alu_rd [4] = '{5'd10, 5'd10, 5'd13, 5'd13};
  logic [4:0] arb_lsu_rd [4] = '{5'd11, 5'd12, 5'd12, 5'd14};
  logic [4:0] arb_exp_wa [4] = '{5'd11, 5'd10, 5'd12, 5'd13};
  logic       arb_exp_ls [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
    rf_mem[3] = 32'h0000_1234;
    bus.rf_r0data = 32'd0;
    bus.rf_r1data = 32'd0;
    idle_inputs();
    nrst = 1'b0;
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_rd    = 5'd4;
    #1;
    check("wren_in_reset", 32'(bus.rf_wren), 32'd0);
    repeat (2) tick();
    idle_inputs();
    nrst = 1'b1;
    tick();

    // reset/idle state
    check("busy_reset", bus.busy_vec, 32'd0);
    check("opv_reset", 32'(bus.op_valid), 32'd0);
    check("opa_reset", bus.op_a, 32'd0);
    check("opb_reset", bus.op_b, 32'd0);
    check("wren_idle", 32'(bus.rf_wren), 32'd0);
    bus.alu_wb_valid = 1'b1;
    #1;
    check("alu_rdy_follow", {bus.alu_wb_ready, bus.lsu_wb_ready}, 32'b10);
    bus.alu_wb_valid = 1'b0;
    bus.lsu_wb_valid = 1'b1;
    #1;
    check("lsu_rdy_follow", {bus.alu_wb_ready, bus.lsu_wb_ready}, 32'b01);
    bus.lsu_wb_valid = 1'b0;
    #1;

    // RAW stall on x5, released by ALU writeback with forwarding
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd5;
    bus.iss_rd_we = 1'b1;
    #1;
    check("iss_rdy_first", 32'(bus.iss_ready), 32'd1);
    tick();
    check("busy_x5", bus.busy_vec, 32'h0000_0020);
    check("opv_first", 32'(bus.op_valid), 32'd1);
    bus.iss_rd_we  = 1'b0;
    bus.iss_rd     = 5'd0;
    bus.iss_rs1    = 5'd5;
    bus.iss_rs1_en = 1'b1;
    #1;
    check("iss_rdy_stall", 32'(bus.iss_ready), 32'd0);
    tick();
    check("opv_stalled", 32'(bus.op_valid), 32'd0);
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_rd    = 5'd5;
    bus.alu_wb_data  = 32'hDEAD_BEEF;
    #1;
    check("iss_rdy_release", 32'(bus.iss_ready), 32'd1);
    check("wren_x5", {bus.rf_wren, bus.wb_err, bus.alu_wb_ready}, 32'b101);
    tick();
    idle_inputs();
    check("opa_forward", bus.op_a, 32'hDEAD_BEEF);
    check("opv_forward", 32'(bus.op_valid), 32'd1);
    check("busy_clear_x5", bus.busy_vec, 32'd0);

    // x0 operand zeroing and register file read
    bus.iss_valid  = 1'b1;
    bus.iss_rs1    = 5'd0;
    bus.iss_rs1_en = 1'b1;
    bus.iss_rs2    = 5'd3;
    bus.iss_rs2_en = 1'b1;
    tick();
    idle_inputs();
    check("opv_x0x3", 32'(bus.op_valid), 32'd1);
    check("opa_x0", bus.op_a, 32'd0);
    check("opb_x3", bus.op_b, 32'h0000_1234);
    tick();
    check("opv_one_cycle", 32'(bus.op_valid), 32'd0);
    check("opb_zero_idle", bus.op_b, 32'd0);

    // arbiter alternation under continuous conflict
    for (int c = 0; c < 4; c++) begin
      bus.alu_wb_valid = 1'b1;
      bus.lsu_wb_valid = 1'b1;
      bus.alu_wb_rd    = arb_alu_rd[c];
      bus.lsu_wb_rd    = arb_lsu_rd[c];
      bus.alu_wb_data  = 32'h100 + 32'(c);
      bus.lsu_wb_data  = 32'h200 + 32'(c);
      #1;
      check($sformatf("arb_lsu_gnt%0d", c), {bus.lsu_wb_ready, bus.alu_wb_ready},
            {30'd0, arb_exp_ls[c], ~arb_exp_ls[c]});
      check($sformatf("arb_waddr%0d", c), 32'(bus.rf_waddr), 32'(arb_exp_wa[c]));
      check($sformatf("arb_wren%0d", c), 32'(bus.rf_wren), 32'd1);
      tick();
    end
    idle_inputs();

    // set wins over same-cycle clear on x7
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    bus.iss_rd_we = 1'b1;
    tick();
    check("busy_x7", bus.busy_vec, 32'h0000_0080);
    bus.lsu_wb_valid = 1'b1;
    bus.lsu_wb_rd    = 5'd7;
    bus.lsu_wb_data  = 32'h7777_0007;
    #1;
    check("iss_rdy_waw_clr", 32'(bus.iss_ready), 32'd1);
    check("wb_err_x7", 32'(bus.wb_err), 32'd0);
    tick();
    idle_inputs();
    check("busy_set_wins", bus.busy_vec, 32'h0000_0080);
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_rd    = 5'd0;
    bus.alu_wb_data  = 32'hFFFF_FFFF;
    #1;
    check("x0_wb", {bus.alu_wb_ready, bus.rf_wren, bus.wb_err}, 32'b100);
    tick();
    idle_inputs();
    check("busy_after_x0", bus.busy_vec, 32'h0000_0080);

    // writeback to a non-busy register flags wb_err but still writes
    bus.alu_wb_valid = 1'b1;
    bus.alu_wb_rd    = 5'd9;
    bus.alu_wb_data  = 32'h0000_0909;
    #1;
    check("wb_err_x9", {bus.wb_err, bus.rf_wren}, 32'b11);
    check("waddr_x9", 32'(bus.rf_waddr), 32'd9);
    tick();
    idle_inputs();
    #1;
    check("wb_err_pulse", 32'(bus.wb_err), 32'd0);
    check("x9_written", rf_mem[9], 32'h0000_0909);

    // reset during a pending stall on x7
    bus.iss_valid  = 1'b1;
    bus.iss_rs1    = 5'd7;
    bus.iss_rs1_en = 1'b1;
    #1;
    check("iss_rdy_pend", 32'(bus.iss_ready), 32'd0);
    nrst = 1'b0;
    #1;
    check("busy_async_rst", bus.busy_vec, 32'd0);
    tick();
    nrst = 1'b1;
    #1;
    check("iss_rdy_after_rst", 32'(bus.iss_ready), 32'd1);
    check("busy_after_rst", bus.busy_vec, 32'd0);
    tick();
    idle_inputs();
    check("opv_after_rst", 32'(bus.op_valid), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
